paddle_ctrl: RTL and testbench



---
 rtl/paddle_if.sv | 22 ++
 rtl/paddle_ctrl.sv | 108 ++++++++++
 tb/tb_paddle_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/paddle_if.sv
// paddle_if: button, VGA timing and draw signals between the timing stage and paddle_ctrl.
interface paddle_if;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] hcount;
    logic [10:0] vcount;
    logic        hcount_ov;
    logic        vcount_ov;
    logic        drawPaddle;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic [10:0] paddle_y;
    modport master(
        output btn_up, btn_down, hcount, vcount, hcount_ov, vcount_ov,
        input  drawPaddle, red, green, blue, paddle_y
    );
    modport slave(
        input  btn_up, btn_down, hcount, vcount, hcount_ov, vcount_ov,
        output drawPaddle, red, green, blue, paddle_y
    );
endinterface

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced two-button vertical paddle, moved once per frame, with registered draw flag.
// Define PADDLE_ACCEL_EN to ramp speed 1..STEP_MAX while held; otherwise speed is fixed at STEP_MAX.
module paddle_ctrl #(
    parameter logic [11:0] PADDLE_X = 12'd16,
    parameter logic [11:0] PADDLE_W = 12'd8,
    parameter logic [10:0] PADDLE_H = 11'd64,
    parameter logic [10:0] VDISP    = 11'd480,
    parameter logic [3:0]  STEP_MAX = 4'd8,
    parameter int          DB_BITS  = 16
) (
    input logic     clk,
    input logic     reset,
    paddle_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    localparam logic [10:0] LIMIT = VDISP - PADDLE_H;
    localparam logic [10:0] Y_RST = LIMIT >> 1;
    logic [1:0]         raw, s1, s2, stable;
    logic [DB_BITS-1:0] cnt [2];
    state_t             state, state_n;
    logic [3:0]         speed_n;
    logic [10:0]        y, y_n;
    logic [11:0]        sum;
    logic               tick, hit;
`ifdef PADDLE_ACCEL_EN
    logic [3:0]         speed;
    logic [1:0]         fc, fc_n;
    logic               restart;
`endif
    assign raw  = {bus.btn_down, bus.btn_up};
    assign tick = bus.hcount_ov && bus.vcount_ov;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) cnt[i] <= '0;
                else if (&cnt[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        y_n     = y;
        speed_n = 4'd1;
        sum     = '0;
`ifdef PADDLE_ACCEL_EN
        fc_n    = fc;
        restart = 1'b0;
`endif
        if (tick) begin
            state_n = stable == 2'b01 ? UP : stable == 2'b10 ? DOWN : IDLE;
`ifdef PADDLE_ACCEL_EN
            restart = state_n == IDLE || state_n != state;
            fc_n    = restart ? 2'd0 : fc + 2'd1;
            speed_n = restart ? 4'd1 : (fc == 2'd3 && speed < STEP_MAX) ? speed + 4'd1 : speed;
`else
            speed_n = state_n == IDLE ? 4'd1 : STEP_MAX;
`endif
            // 12-bit sum so the down clamp sees overflow past LIMIT
            sum = {1'b0, y} + {8'd0, speed_n};
            y_n = state_n == UP   ? (y < {7'd0, speed_n} ? 11'd0 : y - {7'd0, speed_n}) :
                  state_n == DOWN ? (sum > {1'b0, LIMIT} ? LIMIT : sum[10:0]) : y;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            y     <= Y_RST;
`ifdef PADDLE_ACCEL_EN
            speed <= 4'd1;
            fc    <= 2'd0;
`endif
        end else begin
            state <= state_n;
            y     <= y_n;
`ifdef PADDLE_ACCEL_EN
            if (tick) speed <= speed_n;
            fc <= fc_n;
`endif
        end
    end
    assign hit = bus.hcount >= PADDLE_X && bus.hcount < PADDLE_X + PADDLE_W &&
                 {1'b0, bus.vcount} >= {1'b0, y} &&
                 {1'b0, bus.vcount} < {1'b0, y} + {1'b0, PADDLE_H};
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.drawPaddle <= 1'b0;
            bus.red        <= '0;
            bus.green      <= '0;
            bus.blue       <= '0;
        end else begin
            bus.drawPaddle <= hit;
            bus.red        <= hit && state == IDLE ? 3'b111 : 3'b000;
            bus.green      <= hit ? 3'b111 : 3'b000;
            bus.blue       <= hit ? 2'b11 : 2'b00;
        end
    end
    assign bus.paddle_y = y;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed table-driven bench for paddle_ctrl with DB_BITS=4.
module tb_paddle_ctrl;
    typedef struct {
        logic [11:0] h;
        logic [10:0] v;
        logic        d;
        logic [7:0]  c;
    } vec_t;
    typedef struct {
        int t;
        int y;
    } yv_t;
    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] CYAN  = 8'h1F;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    always #5 clk = ~clk;
    paddle_if bus();
    paddle_ctrl #(.DB_BITS(4)) dut(.clk(clk), .reset(reset), .bus(bus));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic tick();
        bus.hcount_ov = 1'b1;
        bus.vcount_ov = 1'b1;
        @(negedge clk);
        bus.hcount_ov = 1'b0;
        bus.vcount_ov = 1'b0;
        @(negedge clk);
    endtask
    task automatic press(input logic u, input logic d);
        bus.btn_up   = u;
        bus.btn_down = d;
        cyc(24);
    endtask
    task automatic pix(input string name, input logic [11:0] h, input logic [10:0] v,
                       input logic d, input logic [7:0] c);
        bus.hcount = h;
        bus.vcount = v;
        @(negedge clk);
        chk({name, "_draw"}, bus.drawPaddle, d);
        chk({name, "_rgb"}, {bus.red, bus.green, bus.blue}, c);
        bus.hcount = 12'd600;
        bus.vcount = 11'd0;
    endtask
    task automatic run(input string name, input yv_t tab[$], input int first, input int last);
        int k = 0;
        for (int t = first; t <= last; t++) begin
            tick();
            if (k < tab.size() && tab[k].t == t) begin
                chk($sformatf("%s_t%0d", name, t), bus.paddle_y, tab[k].y);
                k++;
            end
        end
    endtask
    initial begin
        vec_t tv[$];
        yv_t  up_tab[$];
        yv_t  dn_tab[$];
        tv = '{'{12'd16, 11'd208, 1'b1, WHITE}, '{12'd23, 11'd271, 1'b1, WHITE},
               '{12'd24, 11'd208, 1'b0, 8'h00}, '{12'd15, 11'd208, 1'b0, 8'h00},
               '{12'd16, 11'd207, 1'b0, 8'h00}, '{12'd16, 11'd272, 1'b0, 8'h00},
               '{12'd20, 11'd240, 1'b1, WHITE}, '{12'd0,  11'd0,   1'b0, 8'h00}};
`ifdef PADDLE_ACCEL_EN
        up_tab = '{'{1, 207}, '{4, 204}, '{5, 202}, '{8, 196}, '{28, 96}, '{29, 88}, '{40, 0}, '{42, 0}};
        dn_tab = '{'{1, 1}, '{8, 12}, '{28, 112}, '{65, 408}, '{66, 416}, '{68, 416}};
`else
        up_tab = '{'{1, 200}, '{8, 144}, '{25, 8}, '{26, 0}, '{27, 0}, '{42, 0}};
        dn_tab = '{'{1, 8}, '{8, 64}, '{51, 408}, '{52, 416}, '{68, 416}};
`endif
        reset = 1'b1;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.hcount = 12'd600;
        bus.vcount = 11'd0;
        bus.hcount_ov = 1'b0;
        bus.vcount_ov = 1'b0;
        cyc(2);
        chk("rst_y", bus.paddle_y, 208);
        chk("rst_draw", bus.drawPaddle, 0);
        chk("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
        reset = 1'b0;
        cyc(1);
        for (int i = 0; i < tv.size(); i++) pix($sformatf("vec%0d", i), tv[i].h, tv[i].v, tv[i].d, tv[i].c);
        for (int h = 16; h <= 23; h++)
            for (int v = 208; v <= 271; v += 21) pix($sformatf("sweep_%0d_%0d", h, v), 12'(h), 11'(v), 1'b1, WHITE);
        pix("sweep_v271", 12'd16, 11'd271, 1'b1, WHITE);
        bus.btn_up = 1'b1;
        cyc(10);
        bus.btn_up = 1'b0;
        cyc(24);
        tick();
        chk("glitch_y", bus.paddle_y, 208);
        bus.btn_up = 1'b1;
        cyc(20);
        run("up", up_tab, 1, 42);
        press(1'b0, 1'b1);
        run("down", dn_tab, 1, 68);
        pix("cyan_top", 12'd16, 11'd416, 1'b1, CYAN);
        pix("cyan_bot", 12'd23, 11'd479, 1'b1, CYAN);
        pix("below", 12'd16, 11'd480, 1'b0, 8'h00);
        press(1'b1, 1'b1);
        tick();
        chk("both_y", bus.paddle_y, 416);
        tick();
        chk("both_y2", bus.paddle_y, 416);
        pix("both_white", 12'd16, 11'd420, 1'b1, WHITE);
        press(1'b1, 1'b0);
        tick();
        tick();
`ifdef PADDLE_ACCEL_EN
        chk("hold_y", bus.paddle_y, 414);
`else
        chk("hold_y", bus.paddle_y, 400);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_y", bus.paddle_y, 208);
        chk("mid_rst_draw", bus.drawPaddle, 0);
        tick();
        chk("post_rst_nomove", bus.paddle_y, 208);
        cyc(24);
        tick();
`ifdef PADDLE_ACCEL_EN
        chk("post_rst_speed1", bus.paddle_y, 207);
`else
        chk("post_rst_speed", bus.paddle_y, 200);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
